// File: rtl/alu_issue_stage.sv
// Issue/retire wrapper around the combinational alu_16bit: command FIFO, registered
// ALU drive stage (S1) and a held result register (S2) behind valid/ready handshakes.
module alu_issue_stage #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_opcode,
  input  logic [15:0]              in_a,
  input  logic [15:0]              in_b,
  input  logic                     in_c,
  output logic [15:0]              alu_A,
  output logic [15:0]              alu_B,
  output logic                     alu_c_in,
  output logic [2:0]               alu_opcode,
  input  logic [15:0]              alu_result,
  input  logic                     alu_parity,
  input  logic                     alu_c_out,
  input  logic [2:0]               alu_compare,
  input  logic                     alu_overflow,
  input  logic [15:0]              alu_mul_high,
  input  logic [15:0]              alu_mul_low,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               out_opcode,
  output logic [15:0]              out_result,
  output logic [15:0]              out_mul_high,
  output logic [15:0]              out_mul_low,
  output logic [2:0]               out_compare,
  output logic                     out_parity,
  output logic                     out_overflow,
  output logic                     out_c_out,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         ovf_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
  } cmd_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [15:0] result;
    logic [15:0] mul_high;
    logic [15:0] mul_low;
    logic [2:0]  compare;
    logic        parity;
    logic        overflow;
    logic        c_out;
  } res_t;

  cmd_t           mem_q [DEPTH];
  cmd_t           mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           in_ready_q, in_ready_d;
  logic           s1_valid_q, s1_valid_d;
  cmd_t           s1_q, s1_d;
  logic           out_valid_q, out_valid_d;
  res_t           out_q, out_d;
  logic [CNT_W-1:0] ovf_q, ovf_d;

  logic push, pop, adv2;

  // Next-state for FIFO, drive stage, result register and overflow counter
  always_comb begin
    push        = in_valid && in_ready_q;
    adv2        = s1_valid_q && (!out_valid_q || out_ready);
    pop         = (count_q != '0) && (!s1_valid_q || adv2);
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    s1_d        = s1_q;
    s1_valid_d  = s1_valid_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{opcode: in_opcode, a: in_a, b: in_b, c: in_c};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d    = count_q + CW'(push) - CW'(pop);
    in_ready_d = (count_d < CW'(DEPTH));

    // alu_* keep their last value when S1 drains
    if (pop) begin
      s1_d       = mem_q[rd_ptr_q];
      s1_valid_d = 1'b1;
    end else if (adv2) begin
      s1_valid_d = 1'b0;
    end

    if (adv2) begin
      out_d = '{opcode:   s1_q.opcode,
                result:   alu_result,
                mul_high: alu_mul_high,
                mul_low:  alu_mul_low,
                compare:  alu_compare,
                parity:   alu_parity,
                overflow: alu_overflow,
                c_out:    alu_c_out};
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (out_valid_q && out_ready && out_q.overflow && (ovf_q != '1)) begin
      ovf_d = ovf_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      s1_q        <= s1_d;
      s1_valid_q  <= s1_valid_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign alu_A        = s1_q.a;
  assign alu_B        = s1_q.b;
  assign alu_c_in     = s1_q.c;
  assign alu_opcode   = s1_q.opcode;
  assign out_valid    = out_valid_q;
  assign out_opcode   = out_q.opcode;
  assign out_result   = out_q.result;
  assign out_mul_high = out_q.mul_high;
  assign out_mul_low  = out_q.mul_low;
  assign out_compare  = out_q.compare;
  assign out_parity   = out_q.parity;
  assign out_overflow = out_q.overflow;
  assign out_c_out    = out_q.c_out;
  assign fifo_count   = count_q;
  assign ovf_count    = ovf_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural alu_16bit model on the ALU ports, a
// command scoreboard for ordering/contents, and a CNT_W=2 twin for saturation.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [15:0] result;
    logic [15:0] mul_high;
    logic [15:0] mul_low;
    logic [2:0]  compare;
    logic        parity;
    logic        overflow;
    logic        c_out;
  } alu_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
  } cmd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_c, out_ready;
  logic [2:0]  in_opcode;
  logic [15:0] in_a, in_b;

  logic        in_ready, alu_c_in, out_valid, out_parity, out_overflow, out_c_out;
  logic [15:0] alu_A, alu_B, out_result, out_mul_high, out_mul_low;
  logic [2:0]  alu_opcode, out_opcode, out_compare, fifo_count;
  logic [7:0]  ovf_count;

  logic        s_in_ready, s_alu_c_in, s_out_valid, s_out_parity, s_out_overflow, s_out_c_out;
  logic [15:0] s_alu_A, s_alu_B, s_out_result, s_out_mul_high, s_out_mul_low;
  logic [2:0]  s_alu_opcode, s_out_opcode, s_out_compare, s_fifo_count;
  logic [1:0]  s_ovf_count;

  // alu_16bit behaviour: signed overflow on add/sub, compare one-hot per opcode, even-parity flag
  function automatic alu_t alu_f(input logic [2:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic c);
    alu_t r;
    logic [16:0] s;
    logic [31:0] p;
    r = '0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b} + 17'(c);
        r.result = s[15:0]; r.c_out = s[16];
        r.overflow = (a[15] == b[15]) && (s[15] != a[15]);
      end
      3'd1: begin
        s = {1'b0, a} - {1'b0, b} - 17'(c);
        r.result = s[15:0]; r.c_out = s[16];
        r.overflow = (a[15] != b[15]) && (s[15] != a[15]);
      end
      3'd2: r.result = a & b;
      3'd3: r.result = a | b;
      3'd4: begin r.compare = {2'b00, a == b}; r.result = 16'(a == b); end
      3'd5: begin r.compare = {1'b0, a > b, 1'b0}; r.result = 16'(a > b); end
      3'd6: begin r.compare = {a < b, 2'b00}; r.result = 16'(a < b); end
      default: begin
        p = 32'(a) * 32'(b);
        r.mul_high = p[31:16]; r.mul_low = p[15:0]; r.result = p[15:0];
      end
    endcase
    r.parity = ~^r.result;
    return r;
  endfunction

  alu_t m, ms;
  assign m  = alu_f(alu_opcode, alu_A, alu_B, alu_c_in);
  assign ms = alu_f(s_alu_opcode, s_alu_A, s_alu_B, s_alu_c_in);

  alu_issue_stage #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .alu_A(alu_A), .alu_B(alu_B), .alu_c_in(alu_c_in), .alu_opcode(alu_opcode),
    .alu_result(m.result), .alu_parity(m.parity), .alu_c_out(m.c_out),
    .alu_compare(m.compare), .alu_overflow(m.overflow),
    .alu_mul_high(m.mul_high), .alu_mul_low(m.mul_low),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_result(out_result), .out_mul_high(out_mul_high), .out_mul_low(out_mul_low),
    .out_compare(out_compare), .out_parity(out_parity), .out_overflow(out_overflow),
    .out_c_out(out_c_out), .fifo_count(fifo_count), .ovf_count(ovf_count)
  );

  alu_issue_stage #(.DEPTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .alu_A(s_alu_A), .alu_B(s_alu_B), .alu_c_in(s_alu_c_in), .alu_opcode(s_alu_opcode),
    .alu_result(ms.result), .alu_parity(ms.parity), .alu_c_out(ms.c_out),
    .alu_compare(ms.compare), .alu_overflow(ms.overflow),
    .alu_mul_high(ms.mul_high), .alu_mul_low(ms.mul_low),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_opcode(s_out_opcode),
    .out_result(s_out_result), .out_mul_high(s_out_mul_high), .out_mul_low(s_out_mul_low),
    .out_compare(s_out_compare), .out_parity(s_out_parity), .out_overflow(s_out_overflow),
    .out_c_out(s_out_c_out), .fifo_count(s_fifo_count), .ovf_count(s_ovf_count)
  );

  int   total = 0, bad = 0;
  int   n_push = 0, n_pop = 0, model_ovf = 0, model_ovf2 = 0;
  cmd_t exp_q[$];
  logic have_snap = 1'b0;
  logic [56:0] snap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs at the falling edge: observes the handshakes the next rising edge will register
  task automatic monitor();
    logic [56:0] cur;
    cmd_t e;
    alu_t r;
    cur = {out_opcode, out_result, out_mul_high, out_mul_low, out_compare,
           out_parity, out_overflow, out_c_out};
    chk("ovf_count", 64'(ovf_count), 64'(model_ovf));
    chk("ovf_count_sat", 64'(s_ovf_count), 64'(model_ovf2));
    if (have_snap) chk("stall_hold", 64'({out_valid, cur}), 64'({1'b1, snap}));
    have_snap = out_valid && !out_ready;
    snap = cur;
    if (out_valid && out_ready) begin
      chk("result_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        r = alu_f(e.op, e.a, e.b, e.c);
        chk("result", 64'(cur), 64'({e.op, r}));
        n_pop++;
        if (r.overflow) begin
          if (model_ovf < 255) model_ovf++;
          if (model_ovf2 < 3) model_ovf2++;
        end
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back('{op: in_opcode, a: in_a, b: in_b, c: in_c});
      n_push++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic c);
    in_opcode = op; in_a = a; in_b = b; in_c = c; in_valid = 1'b1;
  endtask

  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic c);
    logic acc;
    acc = 1'b0;
    drive(op, a, b, c);
    for (int k = 0; k < 50 && !acc; k++) begin
      acc = in_ready;
      step();
    end
    in_valid = 1'b0;
    chk("send_accept", 64'(acc), 64'(1));
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      step();
      done = (exp_q.size() == 0) && !out_valid;
    end
    chk("drain", 64'(done), 64'(1));
  endtask

  task automatic wait_out();
    logic seen;
    seen = out_valid;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      seen = out_valid;
    end
    chk("wait_out", 64'(seen), 64'(1));
  endtask

  int p0, a0;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0; in_c = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_fifo_count", 64'(fifo_count), 64'(0));
    chk("rst_alu", 64'({alu_A, alu_B, alu_c_in, alu_opcode}), 64'(0));
    chk("rst_out", 64'({out_opcode, out_result, out_mul_high, out_mul_low, out_compare,
                        out_parity, out_overflow, out_c_out}), 64'(0));
    rst_n = 1'b1;
    step();

    // single ADD through an idle block: alu_* after one edge, out_valid after two
    drive(3'd0, 16'h7FFF, 16'h0001, 1'b0);
    chk("add_in_ready", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    chk("add_lat0_valid", 64'(out_valid), 64'(0));
    chk("add_lat0_count", 64'(fifo_count), 64'(1));
    step();
    chk("add_lat1_alu", 64'({alu_A, alu_B, alu_opcode}), 64'({16'h7FFF, 16'h0001, 3'd0}));
    chk("add_lat1_valid", 64'(out_valid), 64'(0));
    step();
    chk("add_lat2_valid", 64'(out_valid), 64'(1));
    chk("add_result", 64'(out_result), 64'(16'h8000));
    chk("add_overflow", 64'(out_overflow), 64'(1));
    step();
    chk("add_ovf_count", 64'(ovf_count), 64'(1));

    // MUL
    send(3'd7, 16'hFFFF, 16'hFFFF, 1'b0);
    wait_out();
    chk("mul_high", 64'(out_mul_high), 64'(16'hFFFE));
    chk("mul_low", 64'(out_mul_low), 64'(16'h0001));
    chk("mul_parity", 64'(out_parity), 64'(0));
    step();

    // streaming compares, one result per cycle
    drive(3'd4, 16'h00FF, 16'h0F0F, 1'b0); step();
    drive(3'd5, 16'h00FF, 16'h0F0F, 1'b0); step();
    drive(3'd6, 16'h00FF, 16'h0F0F, 1'b0); step();
    in_valid = 1'b0;
    chk("cmp_eq", 64'({out_valid, out_compare}), 64'({1'b1, 3'b000}));
    step();
    chk("cmp_gt", 64'({out_valid, out_compare}), 64'({1'b1, 3'b000}));
    step();
    chk("cmp_lt", 64'({out_valid, out_compare}), 64'({1'b1, 3'b100}));
    drain();

    // four more overflowing adds: 5 in total
    for (int i = 0; i < 4; i++) send(3'd0, 16'h7FFF, 16'(i + 1), 1'b0);
    drain();
    chk("ovf_five", 64'(ovf_count), 64'(5));
    chk("ovf_sat_three", 64'(s_ovf_count), 64'(3));

    // back-pressure fill: 8 presented, DEPTH+2 held
    out_ready = 1'b0;
    a0 = n_push;
    for (int i = 0; i < 8; i++) begin
      drive(3'(i % 4), 16'(16'h1111 * i), 16'(16'h0F0F + i), 1'(i % 2));
      step();
    end
    in_valid = 1'b0;
    chk("fill_accepted", 64'(n_push - a0), 64'(6));
    chk("fill_in_ready", 64'(in_ready), 64'(0));
    chk("fill_count", 64'(fifo_count), 64'(4));
    chk("fill_out_valid", 64'(out_valid), 64'(1));
    step(); step();
    p0 = n_pop;
    drain();
    chk("fill_released", 64'(n_pop - p0), 64'(6));

    // random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_opcode = 3'($urandom_range(0, 7));
      in_a      = 16'($urandom);
      in_b      = 16'($urandom);
      in_c      = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    // reset with 3 queued, one in S1 and one held in S2
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(3'd1, 16'(16'h8000 + i), 16'h0001, 1'b0);
    chk("pre_rst_count", 64'(fifo_count), 64'(3));
    chk("pre_rst_valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_count", 64'(fifo_count), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
    chk("mid_rst_out", 64'({out_result, out_opcode, out_overflow, ovf_count}), 64'(0));
    chk("mid_rst_alu", 64'({alu_A, alu_B, alu_opcode}), 64'(0));
    exp_q.delete();
    have_snap = 1'b0;
    model_ovf = 0;
    model_ovf2 = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_idle", 64'(out_valid), 64'(0));
    end
    p0 = n_pop;
    send(3'd3, 16'hA5A5, 16'h0F0F, 1'b0);
    drain();
    chk("post_rst_one", 64'(n_pop - p0), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
